// File: rtl/mem_stage.sv
// MEM stage of a five-stage pipeline: word-addressed data memory, store
// counter, sticky misalignment flag and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [4:0]  WriteRegM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        StallW,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        MisalignW,
  output logic [15:0] StoreCnt
);

  // Data memory; deliberately has no reset so contents survive reset_n.
  logic [31:0] mem_array [DEPTH];

  logic [AW-1:0] word_idx;
  logic [31:0]   rd_data;
  logic          misaligned;
  logic          store_ok;

  logic        reg_write_q,   reg_write_d;
  logic [4:0]  write_reg_q,   write_reg_d;
  logic        mem_to_reg_q,  mem_to_reg_d;
  logic [31:0] alu_out_q,     alu_out_d;
  logic [31:0] read_data_q,   read_data_d;
  logic        misalign_q,    misalign_d;
  logic [15:0] store_cnt_q,   store_cnt_d;

  // Address decode: upper address bits are dropped so accesses wrap.
  always_comb begin
    word_idx   = ALUOutM[AW+1:2];
    rd_data    = mem_array[word_idx];
    misaligned = (ALUOutM[1:0] != 2'b00);
    store_ok   = MemWriteM & ~misaligned;
  end

  // Aligned stores commit regardless of StallW but never while in reset.
  always_ff @(posedge clk) begin
    if (reset_n && store_ok) begin
      mem_array[word_idx] <= WriteDataM;
    end
  end

  // Next-state for MEM/WB register, sticky flag and store counter.
  always_comb begin
    reg_write_d  = reg_write_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    alu_out_d    = alu_out_q;
    read_data_d  = read_data_q;
    misalign_d   = misalign_q;
    store_cnt_d  = store_cnt_q;
    if (!StallW) begin
      reg_write_d  = RegWriteM;
      write_reg_d  = WriteRegM;
      mem_to_reg_d = MemtoRegM;
      alu_out_d    = ALUOutM;
      read_data_d  = rd_data;
    end
    if ((MemWriteM | MemtoRegM) && misaligned) begin
      misalign_d = 1'b1;
    end
    if (store_ok) begin
      store_cnt_d = store_cnt_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      mem_to_reg_q <= 1'b0;
      alu_out_q    <= 32'd0;
      read_data_q  <= 32'd0;
      misalign_q   <= 1'b0;
      store_cnt_q  <= 16'd0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      misalign_q   <= misalign_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  // Write-back result select and output wiring.
  always_comb begin
    RegWriteW = reg_write_q;
    WriteRegW = write_reg_q;
    ResultW   = mem_to_reg_q ? read_data_q : alu_out_q;
    MisalignW = misalign_q;
    StoreCnt  = store_cnt_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic compared against a behavioural pipeline/memory model.
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_write_m = 1'b0;
  logic        mem_to_reg_m = 1'b0;
  logic        mem_write_m = 1'b0;
  logic [4:0]  write_reg_m = 5'd0;
  logic [31:0] alu_out_m = 32'd0;
  logic [31:0] write_data_m = 32'd0;
  logic        stall_w = 1'b0;
  logic        reg_write_w;
  logic [4:0]  write_reg_w;
  logic [31:0] result_w;
  logic        misalign_w;
  logic [15:0] store_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: memory image and expected visible outputs.
  logic [31:0] model_mem [DEPTH];
  logic        exp_rw;
  logic [4:0]  exp_wr;
  logic [31:0] exp_res;
  logic        exp_mis;
  logic [15:0] exp_cnt;

  mem_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .RegWriteM  (reg_write_m),
    .MemtoRegM  (mem_to_reg_m),
    .MemWriteM  (mem_write_m),
    .WriteRegM  (write_reg_m),
    .ALUOutM    (alu_out_m),
    .WriteDataM (write_data_m),
    .StallW     (stall_w),
    .RegWriteW  (reg_write_w),
    .WriteRegW  (write_reg_w),
    .ResultW    (result_w),
    .MisalignW  (misalign_w),
    .StoreCnt   (store_cnt)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".RegWriteW"}, {31'd0, reg_write_w}, {31'd0, exp_rw});
    checkOutput({tag, ".WriteRegW"}, {27'd0, write_reg_w}, {27'd0, exp_wr});
    checkOutput({tag, ".ResultW"},   result_w, exp_res);
    checkOutput({tag, ".MisalignW"}, {31'd0, misalign_w}, {31'd0, exp_mis});
    checkOutput({tag, ".StoreCnt"},  {16'd0, store_cnt}, {16'd0, exp_cnt});
  endtask

  task automatic clearModelRegs();
    exp_rw  = 1'b0;
    exp_wr  = 5'd0;
    exp_res = 32'd0;
    exp_mis = 1'b0;
    exp_cnt = 16'd0;
  endtask

  // Drive one MEM-cycle operation, clock it, update the model, then check.
  task automatic applyStimulus(input string tag, input logic rw, input logic mtr,
                               input logic mw, input logic [4:0] wreg,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic stall, input bit do_check);
    int idx;
    logic [31:0] pre_read;
    logic mis;
    reg_write_m  = rw;
    mem_to_reg_m = mtr;
    mem_write_m  = mw;
    write_reg_m  = wreg;
    alu_out_m    = addr;
    write_data_m = wdata;
    stall_w      = stall;
    @(posedge clk);
    idx      = int'(addr / 4) % DEPTH;
    pre_read = model_mem[idx];
    mis      = (addr % 4) != 0;
    if (reset_n) begin
      if (!stall) begin
        exp_rw  = rw;
        exp_wr  = wreg;
        exp_res = mtr ? pre_read : addr;
      end
      if ((mw || mtr) && mis) exp_mis = 1'b1;
      if (mw && !mis) begin
        model_mem[idx] = wdata;
        exp_cnt = exp_cnt + 16'd1;
      end
    end else begin
      clearModelRegs();
    end
    #1;
    if (do_check) checkAll(tag);
  endtask

  task automatic randomTraffic(input string tag, input int cycles);
    logic [31:0] addr;
    logic mw, mtr, st;
    for (int i = 0; i < cycles; i++) begin
      addr = $urandom;
      if ($urandom_range(7) != 0) addr[1:0] = 2'b00;
      mw  = ($urandom_range(2) == 0);
      mtr = ($urandom_range(1) == 0);
      st  = ($urandom_range(4) == 0);
      applyStimulus(tag, 1'($urandom_range(1)), mtr, mw, 5'($urandom_range(31)),
                    addr, $urandom, st, 1'b1);
    end
  endtask

  initial begin
    clearModelRegs();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;

    // Reset state, including an edge with a store presented during reset.
    #2;
    checkAll("reset");
    applyStimulus("reset_store", 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0020,
                  32'hCAFE_F00D, 1'b0, 1'b1);
    #2 reset_n = 1'b1;

    // Give every memory word a known value so the model is complete.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("init", 1'b0, 1'b0, 1'b1, 5'd0, 32'(i * 4), $urandom,
                    1'b0, 1'b0);
    end
    checkAll("init_done");

    // Store then immediate load of the same word.
    applyStimulus("st_10", 1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    applyStimulus("ld_10", 1'b1, 1'b1, 1'b0, 5'd4, 32'h10, 32'd0, 1'b0, 1'b1);
    checkOutput("ld_10.value", result_w, 32'hDEAD_BEEF);

    // Plain ALU result passes through.
    applyStimulus("alu_5", 1'b1, 1'b0, 1'b0, 5'd9, 32'h5, 32'd0, 1'b0, 1'b1);
    checkOutput("alu_5.value", result_w, 32'h5);

    // Register 0 is forwarded unchanged.
    applyStimulus("reg0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h77, 32'd0, 1'b0, 1'b1);

    // Misaligned store is dropped; flag sticks through aligned traffic.
    applyStimulus("st_mis", 1'b0, 1'b0, 1'b1, 5'd0, 32'h102, 32'h5555_AAAA, 1'b0, 1'b1);
    checkOutput("st_mis.flag", {31'd0, misalign_w}, 32'd1);
    applyStimulus("ld_100", 1'b1, 1'b1, 1'b0, 5'd2, 32'h100, 32'd0, 1'b0, 1'b1);
    applyStimulus("alu_after", 1'b1, 1'b0, 1'b0, 5'd2, 32'h8, 32'd0, 1'b0, 1'b1);

    // Wrap-around: word 0 aliases byte address 0x100.
    applyStimulus("st_0", 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
    applyStimulus("ld_wrap", 1'b1, 1'b1, 1'b0, 5'd6, 32'h100, 32'd0, 1'b0, 1'b1);
    checkOutput("ld_wrap.value", result_w, 32'h0000_1234);

    // Store and load in the same cycle returns the pre-write data.
    applyStimulus("st_ld", 1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'hABCD_0000, 1'b0, 1'b1);
    checkOutput("st_ld.old", result_w, 32'h0000_1234);

    // Stall holds MEM/WB for two cycles while a store still commits.
    applyStimulus("ld_pre", 1'b1, 1'b1, 1'b0, 5'd8, 32'h10, 32'd0, 1'b0, 1'b1);
    applyStimulus("stall1", 1'b1, 1'b0, 1'b0, 5'd11, 32'h99, 32'd0, 1'b1, 1'b1);
    applyStimulus("stall2", 1'b1, 1'b0, 1'b1, 5'd11, 32'h14, 32'h600D_0001, 1'b1, 1'b1);
    checkOutput("stall.hold", result_w, 32'hDEAD_BEEF);
    applyStimulus("unstall", 1'b1, 1'b0, 1'b0, 5'd11, 32'h99, 32'd0, 1'b0, 1'b1);
    checkOutput("unstall.value", result_w, 32'h99);
    applyStimulus("ld_14", 1'b1, 1'b1, 1'b0, 5'd1, 32'h14, 32'd0, 1'b0, 1'b1);

    randomTraffic("rand1", 300);

    // Asynchronous reset between edges, then memory survives.
    applyStimulus("pre_rst", 1'b1, 1'b0, 1'b0, 5'd12, 32'h4444, 32'd0, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    clearModelRegs();
    #1 checkAll("mid_rst");
    applyStimulus("rst_store", 1'b0, 1'b0, 1'b1, 5'd0, 32'h10, 32'h0BAD_0BAD, 1'b0, 1'b1);
    #3 reset_n = 1'b1;
    applyStimulus("post_rst_ld", 1'b1, 1'b1, 1'b0, 5'd13, 32'h10, 32'd0, 1'b0, 1'b1);

    randomTraffic("rand2", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit data-memory words (power of two, 4..1024).
REQ-002 SHALL have parameter AW, default 6, word-index width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RegWriteM  input  1  register-file write enable from EX/MEM.
REQ-006 SHALL have port MemtoRegM  input  1  select memory data as result (load).
REQ-007 SHALL have port MemWriteM  input  1  store request.
REQ-008 SHALL have port WriteRegM  input  5  destination register number.
REQ-009 SHALL have port ALUOutM  input  32  byte address or ALU result.
REQ-010 SHALL have port WriteDataM  input  32  store data.
REQ-011 SHALL have port StallW  input  1  hold MEM/WB register contents.
REQ-012 SHALL have port RegWriteW  output  1  registered write enable to register file.
REQ-013 SHALL have port WriteRegW  output  5  registered destination register.
REQ-014 SHALL have port ResultW  output  32  write-back value.
REQ-015 SHALL have port MisalignW  output  1  sticky misaligned-access flag.
REQ-016 SHALL have port StoreCnt  output  16  count of committed stores.

Function
REQ-017 SHALL hold a DEPTH x 32 data memory indexed by word index ALUOutM[AW+1:2]; upper address bits ignored (wrap-around).
REQ-018 SHALL read memory combinationally at the current word index during the MEM cycle.
REQ-019 SHALL write WriteDataM to memory on the clk rising edge when MemWriteM=1 and ALUOutM[1:0]=2'b00.
REQ-020 SHALL suppress the write, and leave StoreCnt unchanged, when MemWriteM=1 and ALUOutM[1:0]!=0.
REQ-021 SHALL set MisalignW to 1 on the edge that captures any access with (MemWriteM|MemtoRegM)=1 and ALUOutM[1:0]!=0; MisalignW stays 1 until reset.
REQ-022 SHALL capture RegWriteM, MemtoRegM, WriteRegM, ALUOutM and memory read data into the MEM/WB register on each rising edge when StallW=0.
REQ-023 SHALL hold all MEM/WB register contents when StallW=1; a store still commits, since the MEM/WB stall does not gate memory.
REQ-024 SHALL drive ResultW = registered read data when registered MemtoReg=1, else registered ALUOut.
REQ-025 SHALL give a load one cycle of latency: ResultW is valid in the cycle after the load is presented in MEM.
REQ-026 SHALL return the newly stored word to a load presented in the cycle immediately after a store to the same word, with no stale read.
REQ-027 SHALL increment StoreCnt by 1 per committed aligned store; StoreCnt wraps from 16'hFFFF to 0.
REQ-028 SHALL forward RegWriteW and WriteRegW unchanged, including WriteReg=0; the register file discards writes to register 0.
REQ-029 SHALL treat MemWriteM=1 and MemtoRegM=1 in the same cycle as a store: memory is written and ResultW reflects the pre-write read data.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously force RegWriteW=0, WriteRegW=0, ResultW=0, MisalignW=0 and StoreCnt=0, together with the registered MemtoReg, ALUOut and read data.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL suppress any store presented while reset_n=0.
REQ-033 SHALL resume normal capture on the first rising edge after reset_n deasserts.
REQ-034 SHALL discard an in-flight MEM/WB value when reset asserts mid-operation; it never reaches ResultW.

Verification
REQ-035 SHALL be verified by: store 32'hDEADBEEF at addr 0x10, then load 0x10 next cycle -> ResultW=32'hDEADBEEF one cycle after load, StoreCnt=1.
REQ-036 SHALL be verified by: ALU op with ALUOutM=32'h00000005, MemtoRegM=0, WriteRegM=9, RegWriteM=1 -> next cycle ResultW=5, WriteRegW=9, RegWriteW=1.
REQ-037 SHALL be verified by: store to addr 0x102 -> memory unchanged, StoreCnt unchanged, MisalignW=1 and held after later aligned accesses.
REQ-038 SHALL be verified by: store 32'h1234 at 0x0 and load addr 0x100 with DEPTH=64 -> ResultW=32'h1234 (wrap).
REQ-039 SHALL be verified by: StallW=1 for 2 cycles during a load, with a new ALU op presented -> ResultW holds the previous value and updates on the first unstalled edge.
REQ-040 SHALL be verified by: reset_n pulsed low mid-sequence, between clock edges -> all outputs 0 immediately, and a prior stored word is still readable after reset.
